running_min_tracker: RTL

//   Streaming arg-min stage placed directly downstream of the per-cycle comparator tree.

---
 rtl/min_pkg.sv | 14 +
 rtl/Minimum.sv | 23 ++
 rtl/running_min_tracker.sv | 100 ++++++++++
 3 files changed

// File: rtl/min_pkg.sv
// Shared widths and FSM encoding for the running-minimum tracker.
package min_pkg;

  localparam int unsigned INDEX_W = 16;
  localparam int unsigned VALUE_W = 14;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/Minimum.sv
// Two-input arg-min comparator; on a tie the B input wins.
module Minimum
  import min_pkg::*;
(
  input  logic [INDEX_W-1:0] indexA,
  input  logic [VALUE_W-1:0] valueA,
  input  logic [INDEX_W-1:0] indexB,
  input  logic [VALUE_W-1:0] valueB,
  output logic [INDEX_W-1:0] minIndex_c,
  output logic [VALUE_W-1:0] minValue_c
);

  // A wins only when strictly smaller, so equal values keep B.
  always_comb begin
    minIndex_c = indexB;
    minValue_c = valueB;
    if (valueA < valueB) begin
      minIndex_c = indexA;
      minValue_c = valueA;
    end
  end

endmodule

// File: rtl/running_min_tracker.sv
// Streaming arg-min over a start/inLast framed candidate stream.
module running_min_tracker
  import min_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               inValid,
  output logic               inReady,
  input  logic [INDEX_W-1:0] inIndex,
  input  logic [VALUE_W-1:0] inValue,
  input  logic               inLast,
  output logic               busy,
  output logic               done,
  output logic [INDEX_W-1:0] oIndex,
  output logic [VALUE_W-1:0] oValue,
  output logic [COUNT_W-1:0] oCount
);

  state_t             state, stateNext;
  logic               first, firstNext;
  logic [INDEX_W-1:0] indexNext;
  logic [VALUE_W-1:0] valueNext;
  logic [COUNT_W-1:0] countNext;
  logic [INDEX_W-1:0] cmpIndex;
  logic [VALUE_W-1:0] cmpValue;

  // Candidate on A, stored best on B: ties keep the earlier index.
  Minimum uMin (
    .indexA     (inIndex),
    .valueA     (inValue),
    .indexB     (oIndex),
    .valueB     (oValue),
    .minIndex_c (cmpIndex),
    .minValue_c (cmpValue)
  );

  // Status decodes straight from the state register.
  assign busy    = (state == ACCUM);
  assign inReady = busy;
  assign done    = (state == DONE);

  // State, first flag and result registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      first  <= 1'b0;
      oIndex <= '0;
      oValue <= '1;
      oCount <= '0;
    end else begin
      state  <= stateNext;
      first  <= firstNext;
      oIndex <= indexNext;
      oValue <= valueNext;
      oCount <= countNext;
    end
  end

  // Next-state and result update; the first flag forces a load of the opening candidate.
  always_comb begin
    stateNext = state;
    firstNext = first;
    indexNext = oIndex;
    valueNext = oValue;
    countNext = oCount;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ACCUM;
          firstNext = 1'b1;
          indexNext = '0;
          valueNext = '1;
          countNext = '0;
        end
      end
      ACCUM: begin
        if (inValid) begin
          if (first) begin
            indexNext = inIndex;
            valueNext = inValue;
          end else begin
            indexNext = cmpIndex;
            valueNext = cmpValue;
          end
          firstNext = 1'b0;
          if (oCount != '1) begin
            countNext = oCount + COUNT_W'(1);
          end
          if (inLast) begin
            stateNext = DONE;
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule
